// File: rtl/sap_control_sequencer.sv
// SAP-U control sequencer: one-hot T-state ring plus opcode decode producing
// the one-cycle load/enable lines for the PC, MAR, RAM, IR, A, B, ALU and OUT.
module sap_control_sequencer #(
  parameter int unsigned OP_W     = 4,
  parameter int unsigned T_STATES = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OP_W-1:0]     opcode,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ram_out,
  output logic                ir_load,
  output logic                ir_out,
  output logic                a_load,
  output logic                a_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                sub,
  output logic                out_load,
  output logic                halted,
  output logic [T_STATES-1:0] t_state
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {
    MODE_RUN,
    MODE_HALT
  } mode_t;

  mode_t                mode, mode_next;
  logic [T_STATES-1:0]  ring_next;
  logic                 active;
  logic                 t1, t2, t3, t4, t5, t6;
  logic                 is_lda, is_add, is_sub, is_ldi, is_jmp, is_out, is_hlt;
  logic                 is_mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_state <= {{(T_STATES-1){1'b0}}, 1'b1};
      mode    <= MODE_RUN;
    end else begin
      t_state <= ring_next;
      mode    <= mode_next;
    end
  end

  assign halted = (mode == MODE_HALT);
  assign active = run & ~halted;

  assign t1 = t_state[0];
  assign t2 = t_state[1];
  assign t3 = t_state[2];
  assign t4 = t_state[3];
  assign t5 = t_state[4];
  assign t6 = t_state[5];

  assign is_lda = (opcode == OP_LDA);
  assign is_add = (opcode == OP_ADD);
  assign is_sub = (opcode == OP_SUB);
  assign is_ldi = (opcode == OP_LDI);
  assign is_jmp = (opcode == OP_JMP);
  assign is_out = (opcode == OP_OUT);
  assign is_hlt = (opcode == OP_HLT);
  assign is_mem = is_lda | is_add | is_sub;

  // HLT holds the ring at T4 on the edge that sets halted, instead of advancing.
  always_comb begin
    ring_next = t_state;
    mode_next = mode;
    if (active) begin
      if (t4 && is_hlt)
        mode_next = MODE_HALT;
      else
        ring_next = {t_state[T_STATES-2:0], t_state[T_STATES-1]};
    end
  end

  always_comb begin
    pc_out   = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_out  = 1'b0;
    sub      = 1'b0;
    out_load = 1'b0;
    if (active) begin
      pc_out   = t1;
      pc_inc   = t2;
      pc_load  = t4 & is_jmp;
      mar_load = t1 | (t4 & is_mem);
      ram_out  = t3 | (t5 & is_mem);
      ir_load  = t3;
      ir_out   = t4 & (is_mem | is_ldi | is_jmp);
      a_load   = (t4 & is_ldi) | (t5 & is_lda) | (t6 & (is_add | is_sub));
      a_out    = t4 & is_out;
      b_load   = t5 & (is_add | is_sub);
      alu_out  = t6 & (is_add | is_sub);
      sub      = t6 & is_sub;
      out_load = t4 & is_out;
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: fetch, execute decode, halt,
// run gating and asynchronous reset behaviour.
module tb_sap_control_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic [3:0] opcode;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_out, sub, out_load, halted;
  logic [5:0] t_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [12:0] C_PC_OUT  = 13'h1000;
  localparam logic [12:0] C_PC_INC  = 13'h0800;
  localparam logic [12:0] C_PC_LOAD = 13'h0400;
  localparam logic [12:0] C_MAR     = 13'h0200;
  localparam logic [12:0] C_RAM     = 13'h0100;
  localparam logic [12:0] C_IR_LOAD = 13'h0080;
  localparam logic [12:0] C_IR_OUT  = 13'h0040;
  localparam logic [12:0] C_A_LOAD  = 13'h0020;
  localparam logic [12:0] C_A_OUT   = 13'h0010;
  localparam logic [12:0] C_B_LOAD  = 13'h0008;
  localparam logic [12:0] C_ALU     = 13'h0004;
  localparam logic [12:0] C_SUB     = 13'h0002;
  localparam logic [12:0] C_OUT_LD  = 13'h0001;

  logic [12:0] ctl;
  logic [4:0]  bus;
  assign ctl = {pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out,
                a_load, a_out, b_load, alu_out, sub, out_load};
  assign bus = {pc_out, ram_out, ir_out, a_out, alu_out};

  sap_control_sequencer #(.OP_W(4), .T_STATES(6)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
    .a_out(a_out), .b_load(b_load), .alu_out(alu_out), .sub(sub),
    .out_load(out_load), .halted(halted), .t_state(t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word for T-state t (1-based) and opcode op.
  function automatic logic [12:0] exp_ctl(input int t, input logic [3:0] op);
    logic [12:0] r;
    r = '0;
    case (t)
      1: r = C_PC_OUT | C_MAR;
      2: r = C_PC_INC;
      3: r = C_RAM | C_IR_LOAD;
      4: case (op)
           4'h0, 4'h1, 4'h2: r = C_IR_OUT | C_MAR;
           4'h3:             r = C_IR_OUT | C_A_LOAD;
           4'h6:             r = C_IR_OUT | C_PC_LOAD;
           4'hE:             r = C_A_OUT | C_OUT_LD;
           default:          r = '0;
         endcase
      5: case (op)
           4'h0:       r = C_RAM | C_A_LOAD;
           4'h1, 4'h2: r = C_RAM | C_B_LOAD;
           default:    r = '0;
         endcase
      6: case (op)
           4'h1:    r = C_ALU | C_A_LOAD;
           4'h2:    r = C_ALU | C_A_LOAD | C_SUB;
           default: r = '0;
         endcase
      default: r = '0;
    endcase
    return r;
  endfunction

  // Reset for two cycles, release with run=1; returns at a negedge in T1.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Runs one full instruction from T1; opcode is garbage during fetch.
  task automatic run_instr(input logic [3:0] op);
    logic [5:0] et;
    opcode = ~op;
    for (int k = 1; k <= 6; k++) begin
      et = 6'b000001 << (k - 1);
      #1;
      n_checks++;
      if (t_state !== et) begin
        n_fail++;
        $display("FAIL instr_tstate op=%h T%0d: got %b expected %b", op, k, t_state, et);
      end
      n_checks++;
      if (ctl !== exp_ctl(k, op)) begin
        n_fail++;
        $display("FAIL instr_ctl op=%h T%0d: got %b expected %b", op, k, ctl, exp_ctl(k, op));
      end
      n_checks++;
      if ($countones(bus) > 1) begin
        n_fail++;
        $display("FAIL bus_onehot op=%h T%0d: got %b expected at most one bit", op, k, bus);
      end
      if (k == 3) opcode = op;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    run    = 1'b0;
    opcode = 4'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (t_state !== 6'b000001 || halted !== 1'b0 || ctl !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got t=%b h=%b ctl=%b expected t=000001 h=0 ctl=0", t_state, halted, ctl);
    end
    run = 1'b1;
    #1;
    n_checks++;
    if (ctl !== (C_PC_OUT | C_MAR)) begin
      n_fail++;
      $display("FAIL reset_run_t1: got ctl=%b expected %b", ctl, C_PC_OUT | C_MAR);
    end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (t_state !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_hold_norun: got t=%b expected 000001", t_state);
    end
    run = 1'b1;
    @(negedge clk);
    n_checks++;
    if (t_state !== 6'b000010 || ctl !== C_PC_INC) begin
      n_fail++;
      $display("FAIL reset_first_advance: got t=%b ctl=%b expected t=000010 ctl=%b", t_state, ctl, C_PC_INC);
    end
  endtask

  task automatic test_add_sub();
    do_reset();
    run_instr(4'h1);
    run_instr(4'h2);
    n_checks++;
    if (t_state !== 6'b000001) begin
      n_fail++;
      $display("FAIL add_sub_wrap: got t=%b expected 000001", t_state);
    end
  endtask

  task automatic test_hlt();
    do_reset();
    opcode = 4'h0;
    repeat (3) @(negedge clk);
    opcode = 4'hF;
    #1;
    n_checks++;
    if (t_state !== 6'b001000 || ctl !== 13'h0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_t4: got t=%b ctl=%b h=%b expected t=001000 ctl=0 h=0", t_state, ctl, halted);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (t_state !== 6'b001000 || ctl !== 13'h0 || halted !== 1'b1) begin
        n_fail++;
        $display("FAIL hlt_stuck cyc %0d: got t=%b ctl=%b h=%b expected t=001000 ctl=0 h=1", i, t_state, ctl, halted);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (t_state !== 6'b000001 || halted !== 1'b0 || ctl !== (C_PC_OUT | C_MAR)) begin
      n_fail++;
      $display("FAIL hlt_reset: got t=%b h=%b ctl=%b expected t=000001 h=0 ctl=%b", t_state, halted, ctl, C_PC_OUT | C_MAR);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_run_gating();
    do_reset();
    @(negedge clk);
    run = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 13'h0 || t_state !== 6'b000010) begin
      n_fail++;
      $display("FAIL gate_drop: got t=%b ctl=%b expected t=000010 ctl=0", t_state, ctl);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (ctl !== 13'h0 || t_state !== 6'b000010) begin
        n_fail++;
        $display("FAIL gate_hold: got t=%b ctl=%b expected t=000010 ctl=0", t_state, ctl);
      end
    end
    run = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_PC_INC) begin
      n_fail++;
      $display("FAIL gate_resume: got ctl=%b expected %b", ctl, C_PC_INC);
    end
    @(negedge clk);
    n_checks++;
    if (t_state !== 6'b000100 || ctl !== (C_RAM | C_IR_LOAD)) begin
      n_fail++;
      $display("FAIL gate_next: got t=%b ctl=%b expected t=000100 ctl=%b", t_state, ctl, C_RAM | C_IR_LOAD);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = 4'h0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (t_state !== 6'b010000 || ctl !== (C_RAM | C_A_LOAD)) begin
      n_fail++;
      $display("FAIL mid_t5: got t=%b ctl=%b expected t=010000 ctl=%b", t_state, ctl, C_RAM | C_A_LOAD);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (t_state !== 6'b000001 || a_load !== 1'b0 || ctl !== (C_PC_OUT | C_MAR)) begin
      n_fail++;
      $display("FAIL mid_async_reset: got t=%b a_load=%b ctl=%b expected t=000001 a_load=0 ctl=%b", t_state, a_load, ctl, C_PC_OUT | C_MAR);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int op = 0; op < 15; op++) run_instr(4'(op));
    n_checks++;
    if (t_state !== 6'b000001 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_end: got t=%b h=%b expected t=000001 h=0", t_state, halted);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_sub();
    test_hlt();
    test_run_gating();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
